aes_decipher_iter: RTL and testbench

- Iterative AES inverse-cipher datapath for one 128-bit block; replaces the purely combinational per-round decipher logic with a sequenced core.
- Supports AES-128 and AES-256 at run time, and has a parametrised number of inverse S-box lanes for area/throughput trade-off.
- Round keys come from an external key memory addressed by round_nr. Sits between the top-level AES control FSM and the key-expansion block.

---
 rtl/aes_decipher_iter.sv | 169 ++++++++++++++++
 tb/tb_aes_decipher_iter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_iter.sv
// Iterative AES-128/256 inverse cipher for one 128-bit block. Round keys come from an external
// memory addressed by round_nr, and InvSubBytes is spread over 16/SBOX_LANES sub-cycles per round.
module aes_decipher_iter #(
  parameter int SBOX_LANES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [3:0]   round_nr,
  input  logic [127:0] round_key,
  output logic         ready,
  output logic [127:0] result,
  output logic         result_valid
);

  localparam int         S         = 16 / SBOX_LANES;
  localparam logic [3:0] LAST_LANE = 4'(S - 1);

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
      SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
    $error("SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} fsm_t;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Rows of the InvMixColumns matrix are rotations of (0e 0b 0d 09).
  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] x, m2, m4, m8;
    logic [7:0] p9 [4];
    logic [7:0] pb [4];
    logic [7:0] pd [4];
    logic [7:0] pe [4];
    logic [31:0] o;
    for (int i = 0; i < 4; i++) begin
      x     = a[31 - 8 * i -: 8];
      m2    = xt(x);
      m4    = xt(m2);
      m8    = xt(m4);
      p9[i] = m8 ^ x;
      pb[i] = m8 ^ m2 ^ x;
      pd[i] = m8 ^ m4 ^ x;
      pe[i] = m8 ^ m4 ^ m2;
    end
    o = '0;
    for (int i = 0; i < 4; i++)
      o[31 - 8 * i -: 8] = pe[i] ^ pb[(i + 1) % 4] ^ pd[(i + 2) % 4] ^ p9[(i + 3) % 4];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
    return o;
  endfunction

  // Row r rotates right by r columns; byte index is row + 4*column.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c + 4 - r) % 4)) -: 8];
    return o;
  endfunction

  fsm_t         r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_round_ctr;
  logic [3:0]   r_lane_ctr;
  logic [127:0] r_result;
  logic         r_ready;
  logic         r_result_valid;

  logic [127:0] w_add;
  logic [127:0] w_sbox_state;

  assign w_add = r_state ^ round_key;

  // Only the SBOX_LANES bytes selected by the lane counter pass through an inverse S-box.
  always_comb begin
    // NOTE: default assignment first so every path drives w_sbox_state and no latch is inferred.
    w_sbox_state = r_state;
    for (int j = 0; j < SBOX_LANES; j++)
      w_sbox_state[127 - 8 * (int'(r_lane_ctr) * SBOX_LANES + j) -: 8] =
        inv_sbox(r_state[127 - 8 * (int'(r_lane_ctr) * SBOX_LANES + j) -: 8]);
  end

  // The ciphertext is latched straight into r_state; INIT then applies the last round key.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm          <= IDLE;
      r_state        <= '0;
      r_round_ctr    <= '0;
      r_lane_ctr     <= '0;
      r_result       <= '0;
      r_ready        <= 1'b1;
      r_result_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      case (r_fsm)
        IDLE: begin
          if (next) begin
            r_state        <= block;
            r_round_ctr    <= keylen ? 4'd14 : 4'd10;
            r_ready        <= 1'b0;
            r_result_valid <= 1'b0;
            r_fsm          <= INIT;
          end
        end
        INIT: begin
          r_state     <= inv_shift_rows(w_add);
          r_round_ctr <= r_round_ctr - 4'd1;
          r_fsm       <= SBOX;
        end
        SBOX: begin
          r_state <= w_sbox_state;
          if (r_lane_ctr == LAST_LANE) begin
            r_lane_ctr <= '0;
            r_fsm      <= MAIN;
          end else begin
            r_lane_ctr <= r_lane_ctr + 4'd1;
          end
        end
        MAIN: begin
          if (r_round_ctr != 4'd0) begin
            r_state     <= inv_shift_rows(inv_mix_columns(w_add));
            r_round_ctr <= r_round_ctr - 4'd1;
            r_fsm       <= SBOX;
          end else begin
            r_result       <= w_add;
            r_result_valid <= 1'b1;
            r_ready        <= 1'b1;
            r_fsm          <= IDLE;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  // The round counter doubles as the key-memory address and holds 0 after completion.
  assign round_nr     = r_round_ctr;
  assign ready        = r_ready;
  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_aes_decipher_iter.sv
// Directed FIPS-197 vectors against three lane configurations of aes_decipher_iter; the bench
// derives the round-key memories itself from the cipher keys.
module tb_aes_decipher_iter;

  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ALT   = 128'hdeadbeef0123456789abcdeffedcba98;

  logic         clk;
  logic         rst_n;
  logic         keylen;
  logic [127:0] block;
  logic         key_mode;
  logic         nxt [3];
  logic         rdy [3];
  logic         vld [3];
  logic [3:0]   rn  [3];
  logic [127:0] res [3];
  logic [127:0] rk  [3];
  logic [127:0] rk_tab [2][16];

  int n_checks = 0;
  int n_fail   = 0;

  aes_decipher_iter #(.SBOX_LANES(16)) u_dut16 (
    .clk(clk), .reset_n(rst_n), .next(nxt[0]), .keylen(keylen), .block(block),
    .round_nr(rn[0]), .round_key(rk[0]), .ready(rdy[0]), .result(res[0]), .result_valid(vld[0]));
  aes_decipher_iter #(.SBOX_LANES(4)) u_dut4 (
    .clk(clk), .reset_n(rst_n), .next(nxt[1]), .keylen(keylen), .block(block),
    .round_nr(rn[1]), .round_key(rk[1]), .ready(rdy[1]), .result(res[1]), .result_valid(vld[1]));
  aes_decipher_iter #(.SBOX_LANES(1)) u_dut1 (
    .clk(clk), .reset_n(rst_n), .next(nxt[2]), .keylen(keylen), .block(block),
    .round_nr(rn[2]), .round_key(rk[2]), .ready(rdy[2]), .result(res[2]), .result_valid(vld[2]));

  // Key memory: combinational lookup by each instance's round_nr.
  assign rk[0] = rk_tab[key_mode][rn[0]];
  assign rk[1] = rk_tab[key_mode][rn[1]];
  assign rk[2] = rk_tab[key_mode][rn[2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Forward S-box from its definition: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  task automatic expand(input int sel, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[sel][r] = (r <= nr) ? {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]} : '0;
  endtask

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives the start pulse on a falling edge so the following rising edge samples it.
  task automatic start(input int d, input logic kl, input logic [127:0] blk);
    key_mode = kl;
    keylen   = kl;
    block    = blk;
    nxt[d]   = 1'b1;
    @(negedge clk);
    nxt[d]   = 1'b0;
  endtask

  // Follows one operation to completion, checking busy length, round_nr trace and final result.
  task automatic finish_op(input int d, input int s, input int nr, input string tag,
                           input int inject_at, input logic [127:0] hold_val);
    int cycles, seq_err, hold_err, total;
    logic [3:0] exp_rn;
    cycles = 0; seq_err = 0; hold_err = 0;
    total  = 1 + nr * (s + 1);
    while (rdy[d] !== 1'b1 && cycles < 400) begin
      if (cycles < total) begin
        exp_rn = (cycles == 0) ? 4'(nr) : 4'(nr - 1 - (cycles - 1) / (s + 1));
        if (rn[d] !== exp_rn) seq_err++;
      end
      if (res[d] !== hold_val || vld[d] !== 1'b0) hold_err++;
      if (cycles == inject_at) begin
        block  = ALT;
        keylen = ~keylen;
        nxt[d] = 1'b1;
      end else begin
        nxt[d] = 1'b0;
      end
      cycles++;
      @(negedge clk);
    end
    nxt[d] = 1'b0;
    check({tag, "_busy_cycles"}, 128'(cycles), 128'(total));
    check({tag, "_round_nr_seq_errors"}, 128'(seq_err), 128'd0);
    check({tag, "_hold_errors"}, 128'(hold_err), 128'd0);
    check({tag, "_result"}, res[d], PT);
    check({tag, "_result_valid"}, 128'(vld[d]), 128'd1);
    check({tag, "_round_nr_idle"}, 128'(rn[d]), 128'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    keylen   = 1'b0;
    block    = '0;
    key_mode = 1'b0;
    for (int d = 0; d < 3; d++) nxt[d] = 1'b0;
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    repeat (2) @(negedge clk);
    check("reset_ready", 128'(rdy[0]), 128'd1);
    check("reset_result_valid", 128'(vld[0]), 128'd0);
    check("reset_result", res[0], 128'd0);
    check("reset_round_nr", 128'(rn[0]), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 / C.3 on each lane configuration; result is 0 before the first completion.
    start(0, 1'b0, CT128); finish_op(0, 1, 10, "c1_l16", -1, 128'd0);
    start(0, 1'b1, CT256); finish_op(0, 1, 14, "c3_l16", -1, PT);
    start(1, 1'b0, CT128); finish_op(1, 4, 10, "c1_l4", -1, 128'd0);
    start(1, 1'b1, CT256); finish_op(1, 4, 14, "c3_l4", -1, PT);
    start(2, 1'b0, CT128); finish_op(2, 16, 10, "c1_l1", -1, 128'd0);
    start(2, 1'b1, CT256); finish_op(2, 16, 14, "c3_l1", -1, PT);

    // A second start pulse with new block and keylen mid-operation must be ignored.
    repeat (2) @(negedge clk);
    start(0, 1'b0, CT128); finish_op(0, 1, 10, "ignore_next", 5, PT);

    // Reset in the 7th busy cycle, then a fresh run.
    start(0, 1'b0, CT128);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_ready", 128'(rdy[0]), 128'd1);
    check("midreset_result_valid", 128'(vld[0]), 128'd0);
    check("midreset_result", res[0], 128'd0);
    check("midreset_round_nr", 128'(rn[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start(0, 1'b0, CT128); finish_op(0, 1, 10, "after_reset_c1", -1, 128'd0);

    // Back-to-back: start C.3 in the very cycle ready has risen; the C.1 result must hold.
    start(0, 1'b1, CT256); finish_op(0, 1, 14, "b2b_c3", -1, PT);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
